// File: rtl/capture_sequencer.sv
// capture_sequencer: divider-paced probe capture into a sample FIFO with limit, stop and overrun handling.
// Optional macro TRIGGER_EN adds trig_mask/trig_value and an ARMED state that waits for a pattern match.
module capture_sequencer #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [DIV_W-1:0] divider,
   input  logic [CNT_W-1:0] sample_limit,
   input  logic [15:0]      chan_mask,
`ifdef TRIGGER_EN
   input  logic [15:0]      trig_mask,
   input  logic [15:0]      trig_value,
`endif
   input  logic [15:0]      probe,
   input  logic             fifo_full,
   output logic [15:0]      sample_data,
   output logic             sample_data_avail,
   output logic             busy,
   output logic             done,
   output logic             overrun,
   output logic [CNT_W-1:0] sample_count
);

   typedef enum logic [1:0] {IDLE, ARMED, RUN, OVERRUN} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] div_lat, div_cnt;
   logic [CNT_W-1:0] limit_lat, cnt_inc, cnt_p1;
   logic [15:0]      mask_lat, data_p1;
   logic             vld_p1, done_p1, ovf_flag;
   logic             accept_start, strobe, wr, ovf, hit_limit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

`ifdef TRIGGER_EN
   logic [15:0] tmask_lat, tval_lat;
   logic        trig_hit;
   localparam state_t START_STATE = ARMED;
   assign trig_hit = ((probe & tmask_lat) == (tval_lat & tmask_lat));
`else
   localparam state_t START_STATE = RUN;
`endif

   assign cnt_inc = sat_inc(cnt_p1);

   always_comb begin
      state_nxt    = state;
      accept_start = 1'b0;
      strobe       = 1'b0;
      case (state)
         IDLE, OVERRUN: begin
            if (start && !stop) begin
               accept_start = 1'b1;
               state_nxt    = START_STATE;
            end
         end
`ifdef TRIGGER_EN
         ARMED:   strobe = trig_hit;
`else
         ARMED:   strobe = 1'b0;
`endif
         RUN:     strobe = (div_cnt == div_lat);
         default: state_nxt = IDLE;
      endcase
      wr        = strobe && !fifo_full;
      ovf       = strobe && fifo_full && !stop;
      hit_limit = wr && (limit_lat != '0) && (cnt_inc == limit_lat);
      // A strobe coinciding with stop still writes; stop only decides the next state.
      if (state == ARMED || state == RUN) begin
         if (stop)           state_nxt = IDLE;
         else if (ovf)       state_nxt = OVERRUN;
         else if (hit_limit) state_nxt = IDLE;
         else if (strobe)    state_nxt = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (accept_start) begin
         div_lat   <= divider;
         limit_lat <= sample_limit;
         mask_lat  <= chan_mask;
`ifdef TRIGGER_EN
         tmask_lat <= trig_mask;
         tval_lat  <= trig_value;
`endif
      end
   end

   // Stage p1: registered FIFO write, one cycle after the strobe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_p1  <= '0;
         vld_p1   <= 1'b0;
         done_p1  <= 1'b0;
         cnt_p1   <= '0;
         ovf_flag <= 1'b0;
         div_cnt  <= '0;
      end else begin
         vld_p1  <= wr;
         done_p1 <= hit_limit;
         if (wr) data_p1 <= probe & mask_lat;
         if (accept_start) begin
            cnt_p1   <= '0;
            ovf_flag <= 1'b0;
            div_cnt  <= '0;
         end else begin
            if (wr)  cnt_p1   <= cnt_inc;
            if (ovf) ovf_flag <= 1'b1;
            if (strobe)             div_cnt <= '0;
            else if (state == RUN)  div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   assign sample_data       = data_p1;
   assign sample_data_avail = vld_p1;
   assign done              = done_p1;
   assign overrun           = ovf_flag;
   assign sample_count      = cnt_p1;
   assign busy              = (state == ARMED) || (state == RUN);

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: directed captures queue expected words, a monitor checks each write.
module tb_capture_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, stop, fifo_full;
   logic [15:0] divider;
   logic [31:0] sample_limit;
   logic [15:0] chan_mask, probe;
`ifdef TRIGGER_EN
   logic [15:0] trig_mask, trig_value;
`endif
   logic [15:0] sample_data;
   logic        sample_data_avail, busy, done, overrun;
   logic [31:0] sample_count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_cyc = 0;

   typedef struct {
      logic [15:0] data;
      logic [31:0] cnt;
      logic        dn;
      int          gap;
   } exp_t;
   exp_t exp_q[$];

   capture_sequencer #(.DIV_W(16), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .divider(divider), .sample_limit(sample_limit), .chan_mask(chan_mask),
`ifdef TRIGGER_EN
      .trig_mask(trig_mask), .trig_value(trig_value),
`endif
      .probe(probe), .fifo_full(fifo_full),
      .sample_data(sample_data), .sample_data_avail(sample_data_avail),
      .busy(busy), .done(done), .overrun(overrun), .sample_count(sample_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] d, input logic [31:0] c, input logic dn, input int gap);
      exp_t e;
      e.data = d; e.cnt = c; e.dn = dn; e.gap = gap;
      exp_q.push_back(e);
   endtask

   // Monitor: every write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (sample_data_avail) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {16'h0, sample_data}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_data", {16'h0, sample_data}, {16'h0, e.data});
            chk("wr_count", sample_count, e.cnt);
            chk("wr_done", {31'h0, done}, {31'h0, e.dn});
            if (e.gap != 0) chk("wr_gap", cyc - last_cyc, e.gap);
         end
         last_cyc = cyc;
      end else if (done) begin
         chk("done_without_write", {31'h0, done}, 32'h0);
      end
   end

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; fifo_full = 1'b0;
      divider = '0; sample_limit = '0; chan_mask = '0; probe = '0;
`ifdef TRIGGER_EN
      trig_mask = '0; trig_value = '0;
`endif
      step(3);
      chk("rst_data", {16'h0, sample_data}, 32'h0);
      chk("rst_avail", {31'h0, sample_data_avail}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_overrun", {31'h0, overrun}, 32'h0);
      chk("rst_count", sample_count, 32'h0);
      rst = 1'b1;
      step(2);

      // divider=0, limit=4, counting probe
      divider = 16'd0; sample_limit = 32'd4; chan_mask = 16'hFFFF; probe = 16'h0;
      start = 1'b1; step(1); start = 1'b0;
      chk("t1_busy_run", {31'h0, busy}, 32'h1);
      for (int k = 1; k <= 4; k++) begin
         push(16'(k), 32'(k), k == 4, (k == 1) ? 0 : 1);
         probe = 16'(k);
         step(1);
      end
      probe = 16'd5;
      step(1);
      chk("t1_busy_idle", {31'h0, busy}, 32'h0);
      step(3);
      chk("t1_sb_empty", exp_q.size(), 0);

      // divider=3, unlimited, masked channels
      divider = 16'd3; sample_limit = 32'd0; chan_mask = 16'h00FF; probe = 16'hABCD;
      start = 1'b1; step(1); start = 1'b0;
      for (int i = 1; i <= 5; i++) push(16'h00CD, 32'(i), 1'b0, (i == 1) ? 0 : 4);
      step(20);
      stop = 1'b1; step(1); stop = 1'b0;
      step(3);
      chk("t2_busy_stopped", {31'h0, busy}, 32'h0);
      chk("t2_count", sample_count, 32'd5);
      chk("t2_sb_empty", exp_q.size(), 0);

      // FIFO full on the third strobe
      divider = 16'd1; sample_limit = 32'd0; chan_mask = 16'hFFFF; probe = 16'h1234;
      start = 1'b1; step(1); start = 1'b0;
      push(16'h1234, 32'd1, 1'b0, 0);
      push(16'h1234, 32'd2, 1'b0, 2);
      step(5);
      fifo_full = 1'b1; step(1); fifo_full = 1'b0;
      chk("t3_overrun", {31'h0, overrun}, 32'h1);
      chk("t3_busy", {31'h0, busy}, 32'h0);
      chk("t3_count", sample_count, 32'd2);
      step(3);
      chk("t3_overrun_sticky", {31'h0, overrun}, 32'h1);
      chk("t3_sb_empty", exp_q.size(), 0);
      start = 1'b1; step(1); start = 1'b0;
      chk("t3_restart_overrun", {31'h0, overrun}, 32'h0);
      chk("t3_restart_count", sample_count, 32'h0);
      chk("t3_restart_busy", {31'h0, busy}, 32'h1);
      stop = 1'b1; step(1); stop = 1'b0;
      chk("t3_stop_busy", {31'h0, busy}, 32'h0);
      step(2);

      // stop and start together in IDLE
      start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
      chk("t4_busy", {31'h0, busy}, 32'h0);
      step(3);
      chk("t4_busy_later", {31'h0, busy}, 32'h0);
      chk("t4_sb_empty", exp_q.size(), 0);

      // reset asserted mid-capture
      divider = 16'd0; sample_limit = 32'd0; chan_mask = 16'hFFFF; probe = 16'h55AA;
      start = 1'b1; step(1); start = 1'b0;
      push(16'h55AA, 32'd1, 1'b0, 0);
      push(16'h55AA, 32'd2, 1'b0, 1);
      step(2);
      rst = 1'b0; step(1);
      chk("t5_data", {16'h0, sample_data}, 32'h0);
      chk("t5_avail", {31'h0, sample_data_avail}, 32'h0);
      chk("t5_busy", {31'h0, busy}, 32'h0);
      chk("t5_done", {31'h0, done}, 32'h0);
      chk("t5_overrun", {31'h0, overrun}, 32'h0);
      chk("t5_count", sample_count, 32'h0);
      rst = 1'b1;
      step(4);
      chk("t5_sb_empty", exp_q.size(), 0);

`ifdef TRIGGER_EN
      // trigger on probe bit0 rising in cycle 10
      divider = 16'd2; sample_limit = 32'd2; chan_mask = 16'hFFFF; probe = 16'h0010;
      trig_mask = 16'h0001; trig_value = 16'h0001;
      start = 1'b1; step(1); start = 1'b0;
      chk("t6_busy_armed", {31'h0, busy}, 32'h1);
      push(16'h00A1, 32'd1, 1'b0, 0);
      push(16'h00D1, 32'd2, 1'b1, 3);
      for (int k = 1; k <= 14; k++) begin
         probe = (k < 10) ? 16'(k << 4) : 16'((k << 4) | 1);
         step(1);
      end
      chk("t6_busy_idle", {31'h0, busy}, 32'h0);
      step(3);
      chk("t6_sb_empty", exp_q.size(), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the sample-rate divider.
REQ-002 SHALL have parameter CNT_W, default 32, width of the sample counter and limit.
REQ-003 SHALL have port clk  input  1  fast sampling clock; the only clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-005 SHALL have port start  input  1  one-cycle pulse that starts a capture.
REQ-006 SHALL have port stop  input  1  one-cycle pulse that aborts a capture.
REQ-007 SHALL have port divider  input  DIV_W  sample period minus one, in clk cycles.
REQ-008 SHALL have port sample_limit  input  CNT_W  number of samples to capture; 0 = unlimited.
REQ-009 SHALL have port chan_mask  input  16  per-channel enable; disabled channels read as 0.
REQ-010 SHALL have port probe  input  16  probe inputs, already synchronised to clk.
REQ-011 SHALL have port fifo_full  input  1  write side of the sample FIFO is full.
REQ-012 SHALL have port sample_data  output  16  sample word to the FIFO.
REQ-013 SHALL have port sample_data_avail  output  1  FIFO write enable, one-cycle pulse per word.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE and OVERRUN.
REQ-015 SHALL have port done  output  1  one-cycle pulse when sample_limit is reached.
REQ-016 SHALL have port overrun  output  1  sticky FIFO-overrun flag.
REQ-017 SHALL have port sample_count  output  CNT_W  number of words written in the current capture.

Function
REQ-018 SHALL implement the states IDLE, ARMED, RUN and OVERRUN.
REQ-019 SHALL, on start in IDLE or OVERRUN, latch divider, sample_limit and chan_mask; clear sample_count and overrun; reset the divider counter to 0; and enter RUN (ARMED when triggering is compiled in).
REQ-020 SHALL ignore start while in ARMED or RUN.
REQ-021 SHALL, in RUN, raise an internal strobe when the divider counter equals the latched divider, then reload the counter to 0; divider=0 gives a strobe every cycle.
REQ-022 SHALL, on a strobe with fifo_full=0, register probe & chan_mask into sample_data and pulse sample_data_avail exactly one cycle later (latency 1), and increment sample_count.
REQ-023 SHALL hold sample_data unchanged and keep sample_data_avail at 0 on cycles without a write.
REQ-024 SHALL, on a strobe with fifo_full=1, write nothing, set overrun=1 and enter OVERRUN; overrun stays 1 until the next accepted start or reset.
REQ-025 SHALL, when a write makes sample_count equal a nonzero latched sample_limit, pulse done in the same cycle as that sample_data_avail and return to IDLE.
REQ-026 SHALL saturate sample_count at all-ones when sample_limit=0.
REQ-027 SHALL, on stop in ARMED or RUN, enter IDLE on the next cycle, and SHALL still emit a write already scheduled for that cycle.
REQ-028 SHALL give stop priority when stop and start are asserted in the same cycle: no capture is started.

Reset
REQ-029 SHALL, while rst=0, force IDLE with sample_data=0, sample_data_avail=0, busy=0, done=0, overrun=0, sample_count=0 and the divider counter=0.
REQ-030 SHALL abort an active capture if rst is asserted mid-capture, with no further writes.

Configuration
REQ-031 SHALL, with TRIGGER_EN defined, add inputs trig_mask[15:0] and trig_value[15:0], latched on start, and the ARMED state.
REQ-032 SHALL, with TRIGGER_EN defined, go from ARMED to RUN on the first cycle where (probe & trig_mask) == (trig_value & trig_mask), and strobe in that same cycle so the matching sample is the first word written.
REQ-033 SHALL treat trig_mask=0 as an immediate match on the first ARMED cycle.
REQ-034 SHALL, without TRIGGER_EN, omit the trigger ports and make ARMED unreachable: start goes directly to RUN.

Verification
REQ-035 Bench SHALL check: divider=0, limit=4, probe counting 1,2,3,... -> four consecutive avail pulses carrying 1..4, done with the 4th, then IDLE.
REQ-036 Bench SHALL check: divider=3, limit=0, chan_mask=16'h00FF, probe=16'hABCD -> avail every 4 cycles with data 16'h00CD.
REQ-037 Bench SHALL check: fifo_full=1 on the 3rd strobe -> exactly 2 writes, overrun=1, busy=0; a new start -> overrun=0 and sample_count=0.
REQ-038 Bench SHALL check: stop and start in the same cycle in IDLE -> state stays IDLE and busy=0.
REQ-039 Bench SHALL check: TRIGGER_EN, trig_mask=16'h0001, trig_value=1, probe bit0 rising at cycle 10 -> first write carries the cycle-10 probe value.
REQ-040 Bench SHALL check: rst=0 during RUN -> all outputs 0 on the next cycle and no avail pulse afterwards.
